if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage and IF/ID pipeline register. It produces the fetched instruction and its pre-split fields (`rd`, `rs1`, `rs2`, `opcode`) that the decode stage consumes. It owns the PC, issues requests to instruction memory over a request/grant/response handshake, and absorbs hazard stalls, flushes and branch redirects.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `imem_req`  out  1: fetch request.
- `imem_addr`  out  32: fetch address, word aligned.
- `imem_gnt`  in  1: request accepted in this cycle.
- `imem_rvalid`  in  1: response valid. Arrives at least 1 cycle after the grant, in order.
- `imem_rdata`  in  `INST_WIDTH`: response instruction.
- `stall`  in  1: hazard unit; hold IF/ID.
- `flush`  in  1: invalidate IF/ID and the hold buffer.
- `redirect_valid`  in  1: branch/jump taken.
- `redirect_pc`  in  32: target; bits [1:0] are ignored and treated as 0.
- `id_valid`  out  1: IF/ID holds a real instruction.
- `id_pc`  out  32: PC of `id_inst`.
- `id_inst`  out  `INST_WIDTH`: instruction to decode.
- `id_opcode`  out  `OPCODE_WIDTH`: `id_inst[6:0]`.
- `id_rd`  out  `REG_ADDR_WIDTH`: `id_inst[11:7]`.
- `id_rs1`  out  `REG_ADDR_WIDTH`: `id_inst[19:15]`.
- `id_rs2`  out  `REG_ADDR_WIDTH`: `id_inst[24:20]`.

## Operation
- Registers:
  - `pc`: next fetch address.
  - `req_pc`: address of the outstanding request.
  - One-entry hold buffer (`buf_valid`, `buf_inst`, `buf_pc`).
  - FSM.
  - IF/ID register.
- FSM states:
  - FETCH: `imem_req`=1, `imem_addr`=`pc`. On grant: `req_pc`←`pc`, `pc`←`pc`+4 (32-bit wrap), go to WAIT.
  - WAIT: one request outstanding. On `imem_rvalid`:
    - If `stall`=0, load IF/ID.
    - Else write the hold buffer and go to FULL.
  - WAIT (same-cycle refetch): when the response is consumed directly with no stall, redirect or flush, `imem_req` is also asserted at `pc`. If granted, stay in WAIT; otherwise go to FETCH.
  - FULL: no request. When `stall`=0, IF/ID←buffer and go to FETCH.
  - DROP: outstanding response must be discarded. On `imem_rvalid`, discard it and go to FETCH.
- IF/ID update when `stall`=0:
  - Buffer valid: load the buffer.
  - Else, response arriving: load the response.
  - Else: bubble (`id_valid`=0, `id_inst`=NOP 32'h0000_0013).
- When `stall`=1, all IF/ID outputs hold.
- Redirect (highest priority): `pc`←`redirect_pc`, `id_valid`←0, buffer cleared, then:
  - WAIT with no response this cycle, or FETCH with grant this cycle: go to DROP.
  - Otherwise: go to FETCH.
- Redirect in FETCH without grant: `imem_req` drops for that cycle; the request resumes next cycle at the new PC. Instruction memory tolerates retraction of an ungranted request.
- Flush without redirect: `id_valid`←0 and buffer cleared. A response arriving in that cycle is dropped; an outstanding one goes to DROP. `pc` is unchanged.
- Priority: redirect > flush > stall. Flush overrides stall.
- Field outputs are always slices of `id_inst`, including bubbles (so a bubble reads `rd`=0).

## Timing
- Reset values:
  - state=FETCH, `pc`=`RESET_PC`.
  - `imem_req`=0 while `rst`=0; it rises combinationally in FETCH once `rst`=1.
  - `id_valid`=0, `id_inst`=32'h0000_0013, `id_pc`=0, buffer empty.
- Reset asserted mid-transaction abandons everything. An `imem_rvalid` arriving after reset release for a pre-reset request is not supported.
- Latency: grant at cycle N, rvalid at N+k (k≥1), `id_valid` visible at N+k+1.
- Throughput: with k=1 and grant always high, one instruction per cycle after the first 2-cycle fill.
- `imem_addr` is stable while `imem_req`=1 and no grant, except on a redirect.
- At most one request is outstanding at any time.

## Structure
- Shared constants `INST_WIDTH`, `REG_ADDR_WIDTH`, `OPCODE_WIDTH` come from `const.v`. Add there:
  - `NOP_INST` (32'h0000_0013).
  - The FSM state encodings.
- Natural sub-module: `if_id_reg` (IF/ID register with stall/flush/bubble insertion).

## Test plan
- Reset release, `RESET_PC`=0, grant=1, k=1 → addresses 0,4,8,… on consecutive cycles; `id_valid` first high 2 cycles after the first request; `id_pc`=0.
- `imem_rdata`=32'h00A30293 delivered → `id_opcode`=7'h13, `id_rd`=5, `id_rs1`=6, `id_rs2`=10.
- `stall` held 3 cycles while a response arrives → IF/ID holds its value, the response goes to the buffer, no new request; after release the buffered instruction appears next, with no loss or duplication.
- `redirect_valid`, `redirect_pc`=32'h100 while in WAIT, response arrives 2 cycles later → that response is discarded, next request at 32'h100, `id_valid`=0 in between.
- `stall`=1 and `flush`=1 in the same cycle → `id_valid`=0 next cycle and the buffer is empty.
- `pc`=32'hFFFF_FFFC granted → next request address is 32'h0000_0000.

Source files
------------

// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared widths, the NOP encoding and the fetch FSM state encoding.
// Contents: INST_WIDTH, REG_ADDR_WIDTH, OPCODE_WIDTH, NOP_INST, fetch_state_e.
// Imported by if_stage and its IF/ID register sub-module.
package if_stage_pkg;

  localparam int INST_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int OPCODE_WIDTH   = 7;

  // addi x0, x0, 0
  localparam logic [INST_WIDTH-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,  // request pending at pc
    ST_WAIT  = 2'd1,  // one request outstanding, response wanted
    ST_FULL  = 2'd2,  // response parked in the hold buffer, no request
    ST_DROP  = 2'd3   // one request outstanding, response to be discarded
  } fetch_state_e;

endpackage

// File: rtl/if_stage_if_id_reg.sv
// if_stage_if_id_reg: IF/ID pipeline register with stall hold, kill and bubble insertion.
// Ports: kill_i/stall_i control, load_* candidate instruction, id_* registered instruction and field slices.
// Latency 1 cycle; stall_i holds every output, kill_i (flush or redirect) overrides stall_i.
module if_stage_if_id_reg
  import if_stage_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      kill_i,
  input  logic                      stall_i,
  input  logic                      load_i,
  input  logic [INST_WIDTH-1:0]     load_inst_i,
  input  logic [31:0]               load_pc_i,
  output logic                      id_valid_o,
  output logic [31:0]               id_pc_o,
  output logic [INST_WIDTH-1:0]     id_inst_o,
  output logic [OPCODE_WIDTH-1:0]   id_opcode_o,
  output logic [REG_ADDR_WIDTH-1:0] id_rd_o,
  output logic [REG_ADDR_WIDTH-1:0] id_rs1_o,
  output logic [REG_ADDR_WIDTH-1:0] id_rs2_o
);

  logic                  valid_q;
  logic [31:0]           pc_q;
  logic [INST_WIDTH-1:0] inst_q;

  // Bubbles keep the last pc; only valid and inst are defined for them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= NOP_INST;
    end else if (kill_i) begin
      valid_q <= 1'b0;
      inst_q  <= NOP_INST;
    end else if (!stall_i) begin
      if (load_i) begin
        valid_q <= 1'b1;
        pc_q    <= load_pc_i;
        inst_q  <= load_inst_i;
      end else begin
        valid_q <= 1'b0;
        inst_q  <= NOP_INST;
      end
    end
  end

  assign id_valid_o  = valid_q;
  assign id_pc_o     = pc_q;
  assign id_inst_o   = inst_q;
  // Fields are plain slices, so a bubble decodes as the NOP's fields.
  assign id_opcode_o = inst_q[6:0];
  assign id_rd_o     = inst_q[11:7];
  assign id_rs1_o    = inst_q[19:15];
  assign id_rs2_o    = inst_q[24:20];

endmodule

// File: rtl/if_stage.sv
// if_stage: PC owner, imem request/grant/response sequencer, one-entry hold buffer, IF/ID register.
// Ports: imem_* fetch handshake; stall/flush/redirect_* control; id_* instruction and pre-split fields.
// Grant at N, response at N+k, id_valid at N+k+1; a stalled response parks in the hold buffer and fetch pauses.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      imem_req,
  output logic [31:0]               imem_addr,
  input  logic                      imem_gnt,
  input  logic                      imem_rvalid,
  input  logic [INST_WIDTH-1:0]     imem_rdata,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_pc,
  output logic                      id_valid,
  output logic [31:0]               id_pc,
  output logic [INST_WIDTH-1:0]     id_inst,
  output logic [OPCODE_WIDTH-1:0]   id_opcode,
  output logic [REG_ADDR_WIDTH-1:0] id_rd,
  output logic [REG_ADDR_WIDTH-1:0] id_rs1,
  output logic [REG_ADDR_WIDTH-1:0] id_rs2
);

  fetch_state_e          state_q;
  logic [31:0]           pc_q;
  logic [31:0]           req_pc_q;
  logic                  buf_valid_q;
  logic [INST_WIDTH-1:0] buf_inst_q;
  logic [31:0]           buf_pc_q;

  logic rsp_live;
  logic consume;
  logic gnt;

  assign rsp_live = (state_q == ST_WAIT) && imem_rvalid;
  // Response goes straight into IF/ID this cycle, freeing the slot for a back-to-back request.
  assign consume  = rsp_live && !stall && !flush && !redirect_valid;

  // Gated by rst so no request is shown while the block is held in reset.
  assign imem_req  = rst && (((state_q == ST_FETCH) && !redirect_valid) || consume);
  assign imem_addr = pc_q;
  assign gnt       = imem_req && imem_gnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      buf_valid_q <= 1'b0;
      buf_inst_q  <= NOP_INST;
      buf_pc_q    <= '0;
    end else if (redirect_valid) begin
      pc_q        <= redirect_pc & ~32'h3;
      buf_valid_q <= 1'b0;
      // Anything still in flight must have its response swallowed.
      if ((((state_q == ST_WAIT) || (state_q == ST_DROP)) && !imem_rvalid) || gnt)
        state_q <= ST_DROP;
      else
        state_q <= ST_FETCH;
    end else begin
      if (gnt) begin
        req_pc_q <= pc_q;
        pc_q     <= pc_q + 32'd4;
      end
      case (state_q)
        ST_FETCH: if (gnt) state_q <= ST_WAIT;
        ST_WAIT: begin
          if (imem_rvalid) begin
            if (flush) begin
              state_q <= ST_FETCH;
            end else if (stall) begin
              buf_valid_q <= 1'b1;
              buf_inst_q  <= imem_rdata;
              buf_pc_q    <= req_pc_q;
              state_q     <= ST_FULL;
            end else begin
              state_q <= gnt ? ST_WAIT : ST_FETCH;
            end
          end else if (flush) begin
            state_q <= ST_DROP;
          end
        end
        ST_FULL: begin
          if (flush || !stall) begin
            buf_valid_q <= 1'b0;
            state_q     <= ST_FETCH;
          end
        end
        ST_DROP: if (imem_rvalid) state_q <= ST_FETCH;
        default: state_q <= ST_FETCH;
      endcase
    end
  end

  if_stage_if_id_reg u_if_id (
    .clk        (clk),
    .rst        (rst),
    .kill_i     (redirect_valid || flush),
    .stall_i    (stall),
    .load_i     (buf_valid_q || rsp_live),
    .load_inst_i(buf_valid_q ? buf_inst_q : imem_rdata),
    .load_pc_i  (buf_valid_q ? buf_pc_q : req_pc_q),
    .id_valid_o (id_valid),
    .id_pc_o    (id_pc),
    .id_inst_o  (id_inst),
    .id_opcode_o(id_opcode),
    .id_rd_o    (id_rd),
    .id_rs1_o   (id_rs1),
    .id_rs2_o   (id_rs2)
  );

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
  import if_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [6:0]  id_opcode;
  logic [4:0]  id_rd;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .id_opcode(id_opcode), .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lat = 1;
  int first_req = -1;
  int first_vld = -1;
  logic last_req;

  // Instruction memory: responses in order, lat cycles after each grant.
  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t pq[$];
  logic [31:0] gnt_log[$];

  // Behavioural model: program-order view of fetch.
  logic [31:0] m_pc = 32'h0;
  logic        m_out = 1'b0;     // one request in flight
  logic        m_dead = 1'b0;    // its response must be thrown away
  logic [31:0] m_out_pc = '0;
  logic        m_hold_v = 1'b0;
  logic [31:0] m_hold_pc = '0, m_hold_inst = '0;
  logic        m_idv = 1'b0;
  logic [31:0] m_idpc = '0, m_idinst = 32'h0000_0013;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == 32'h8) ? 32'h00A3_0293 : (a ^ 32'hA500_0000);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_id();
    chk("id_valid", {31'b0, id_valid}, {31'b0, m_idv});
    chk("id_inst", id_inst, m_idinst);
    chk("id_opcode", {25'b0, id_opcode}, {25'b0, m_idinst[6:0]});
    chk("id_rd", {27'b0, id_rd}, {27'b0, m_idinst[11:7]});
    chk("id_rs1", {27'b0, id_rs1}, {27'b0, m_idinst[19:15]});
    chk("id_rs2", {27'b0, id_rs2}, {27'b0, m_idinst[24:20]});
    if (m_idv) chk("id_pc", id_pc, m_idpc);
  endtask

  // One clock: called at posedge+1, drives inputs, checks combinational
  // outputs, advances the model at the edge, then checks IF/ID.
  task automatic step(input logic s, input logic f, input logic r,
                      input logic [31:0] rp, input logic g);
    logic exp_req, rsp, live, grant_dut, grant_m;
    logic [31:0] gaddr, rinst, rsp_pc;
    int cur;
    stall = s; flush = f; redirect_valid = r; redirect_pc = rp; imem_gnt = g;
    if (pq.size() > 0 && pq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem(pq[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    rsp    = imem_rvalid && m_out;
    rinst  = imem_rdata;
    rsp_pc = m_out_pc;
    // Request whenever nothing is parked and the fetch slot is free or freed this cycle.
    exp_req = !r && !m_hold_v && (!m_out || (rsp && !m_dead && !s && !f));
    #1;
    last_req = imem_req;
    chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    if (imem_req && first_req < 0) first_req = cyc;
    grant_dut = imem_req && imem_gnt;
    gaddr = imem_addr;
    cur = cyc;
    @(posedge clk);
    cyc++;
    if (imem_rvalid && pq.size() > 0) void'(pq.pop_front());
    if (grant_dut) begin
      pq.push_back('{gaddr, cur + lat});
      gnt_log.push_back(gaddr);
    end
    grant_m = exp_req && g;
    live = rsp && !m_dead && !r && !f;
    if (rsp) begin m_out = 1'b0; m_dead = 1'b0; end
    if (r) begin
      m_pc = rp & ~32'h3;
      m_idv = 1'b0; m_idinst = NOP_INST; m_hold_v = 1'b0;
      if (m_out) m_dead = 1'b1;
    end else begin
      if (f) begin
        m_idv = 1'b0; m_idinst = NOP_INST; m_hold_v = 1'b0;
        if (m_out) m_dead = 1'b1;
      end else if (s) begin
        if (live) begin m_hold_v = 1'b1; m_hold_pc = rsp_pc; m_hold_inst = rinst; end
      end else if (m_hold_v) begin
        m_idv = 1'b1; m_idpc = m_hold_pc; m_idinst = m_hold_inst; m_hold_v = 1'b0;
      end else if (live) begin
        m_idv = 1'b1; m_idpc = rsp_pc; m_idinst = rinst;
      end else begin
        m_idv = 1'b0; m_idinst = NOP_INST;
      end
      if (grant_m) begin
        m_out = 1'b1; m_dead = 1'b0; m_out_pc = m_pc; m_pc = m_pc + 32'd4;
      end
    end
    #1;
    if (id_valid && first_vld < 0) first_vld = cyc;
    check_id();
  endtask

  initial begin
    int mark;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_id_inst", id_inst, 32'h0000_0013);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_rd", {27'b0, id_rd}, 32'd0);
    rst = 1'b1;

    // Streaming fill: grant always, k=1
    repeat (4) step(0, 0, 0, 32'h0, 1);
    chk("fill_cnt", gnt_log.size(), 32'd4);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++) chk("fill_addr", gnt_log[i], 32'(i * 4));
    chk("fill_latency", 32'(first_vld - first_req), 32'd2);
    chk("dec_valid", {31'b0, id_valid}, 32'd1);
    chk("dec_pc", id_pc, 32'h8);
    chk("dec_inst", id_inst, 32'h00A3_0293);
    chk("dec_opcode", {25'b0, id_opcode}, 32'h13);
    chk("dec_rd", {27'b0, id_rd}, 32'd5);
    chk("dec_rs1", {27'b0, id_rs1}, 32'd6);
    chk("dec_rs2", {27'b0, id_rs2}, 32'd10);

    // Stall for 3 cycles while the response for 0xC arrives
    repeat (3) begin
      step(1, 0, 0, 32'h0, 1);
      chk("stall_no_req", {31'b0, last_req}, 32'd0);
      chk("stall_hold_pc", id_pc, 32'h8);
      chk("stall_hold_vld", {31'b0, id_valid}, 32'd1);
    end
    step(0, 0, 0, 32'h0, 1);
    chk("unstall_pc", id_pc, 32'hC);
    chk("unstall_vld", {31'b0, id_valid}, 32'd1);

    // Redirect while waiting, response arrives two cycles later
    lat = 3;
    step(0, 0, 0, 32'h0, 1);
    chk("next_after_buf", (gnt_log.size() > 4) ? gnt_log[4] : 32'hFFFF_FFFF, 32'h10);
    step(0, 0, 1, 32'h103, 1);
    chk("redir_vld0", {31'b0, id_valid}, 32'd0);
    step(0, 0, 0, 32'h0, 1);
    chk("drop_no_req", {31'b0, last_req}, 32'd0);
    chk("redir_vld1", {31'b0, id_valid}, 32'd0);
    step(0, 0, 0, 32'h0, 1);
    chk("drop_no_req2", {31'b0, last_req}, 32'd0);
    chk("redir_vld2", {31'b0, id_valid}, 32'd0);
    lat = 1;
    step(0, 0, 0, 32'h0, 1);
    chk("redir_target", (gnt_log.size() > 5) ? gnt_log[5] : 32'hFFFF_FFFF, 32'h100);
    chk("redir_vld3", {31'b0, id_valid}, 32'd0);
    step(0, 0, 0, 32'h0, 1);

    // Stall and flush together with the buffer occupied
    step(1, 0, 0, 32'h0, 1);
    chk("pre_flush_pc", id_pc, 32'h100);
    step(1, 1, 0, 32'h0, 1);
    chk("flush_vld", {31'b0, id_valid}, 32'd0);
    step(0, 0, 0, 32'h0, 1);
    chk("flush_buf_empty", {31'b0, id_valid}, 32'd0);
    chk("flush_next_addr", (gnt_log.size() > 7) ? gnt_log[7] : 32'hFFFF_FFFF, 32'h108);
    step(0, 0, 0, 32'h0, 1);

    // Withheld grants: address must stay put
    step(0, 0, 0, 32'h0, 0);
    step(0, 0, 0, 32'h0, 0);
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);

    // Mixed directed vectors
    lat = 2;
    step(0, 0, 0, 32'h0, 1);
    step(0, 1, 0, 32'h0, 1);
    repeat (4) step(0, 0, 0, 32'h0, 1);
    step(1, 0, 0, 32'h0, 1);
    step(0, 0, 1, 32'h200, 1);
    repeat (6) step(0, 0, 0, 32'h0, 1);
    step(1, 0, 0, 32'h0, 1);
    step(1, 0, 0, 32'h0, 1);
    step(0, 0, 1, 32'h302, 1);
    repeat (6) step(0, 0, 0, 32'h0, 1);

    // PC wrap at the top of the address space
    lat = 1;
    mark = gnt_log.size();
    step(0, 0, 1, 32'hFFFF_FFFC, 1);
    repeat (6) step(0, 0, 0, 32'h0, 1);
    chk("wrap_cnt", {31'b0, gnt_log.size() >= mark + 2}, 32'd1);
    chk("wrap_first", (gnt_log.size() > mark) ? gnt_log[mark] : 32'h1, 32'hFFFF_FFFC);
    chk("wrap_next", (gnt_log.size() > mark + 1) ? gnt_log[mark + 1] : 32'h1, 32'h0000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
